riscv_mcsr_unit: RTL and testbench
==================================

# riscv_mcsr_unit

Parametrised machine-mode CSR unit for the 5-stage RISC-V core: the successor to the current CSR file. It adds read-modify-write CSR ops (RW/RS/RC) with per-register write masks and illegal-access detection. It also provides synchronised interrupt inputs with pending/enable arbitration, direct and vectored trap redirection, counter inhibit, and optional HPM counters. It sits beside the EX/MEM boundary: the pipeline issues CSR ops, exceptions, interrupt acks and MRETs, and the unit returns read data and a registered redirect PC.

## Interface
- XLEN, 64, register and data width (32 or 64)
- HART_ID, 0, constant returned by mhartid
- MISA_VAL, 64'h8000_0000_0014_1101, constant returned by misa (truncated to XLEN)
- IRQ_SYNC_STAGES, 2, synchroniser depth on each irq input (>=2)
- NUM_HPM, 4, number of mhpmcounter/mhpmevent pairs (1..29), used only with CSR_HPM_EN
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_req  in  1  CSR instruction valid this cycle
- csr_op  in  2  01 RW, 10 RS, 11 RC; 00 is a read with no write
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1 value or zero-extended uimm
- csr_rdata  out  XLEN  old CSR value, combinational
- csr_illegal  out  1  access is illegal (combinational, qualified by csr_req)
- exc_valid  in  1  synchronous exception commit
- exc_code  in  5  exception cause code
- exc_pc  in  XLEN  faulting PC
- exc_tval  in  XLEN  trap value
- irq_ext, irq_timer, irq_soft  in  1 each  asynchronous level interrupts
- irq_pending  out  1  an enabled interrupt is pending
- irq_code  out  5  highest-priority pending code
- irq_ack  in  1  pipeline takes the interrupt
- irq_pc  in  XLEN  PC saved on interrupt
- mret_valid  in  1  MRET commit
- retire  in  1  one instruction retired
- redirect_valid  out  1  registered one-cycle pulse
- redirect_pc  out  XLEN  target PC
- mstatus_o, mie_o  out  XLEN  live register views

## Operation
- Reset state: all CSRs are zero except mstatus.MPP = 2'b11. redirect_valid, redirect_pc and irq_pending are 0.
- Write value: RW → wdata; RS → old | wdata; RC → old & ~wdata. Masked by the register's writable bits.
- A write occurs when csr_req is high, csr_illegal is low and csr_op != 00.
- mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 11. All other bits read 0.
- mtvec: MODE[1:0] accepts only 0 (direct) or 1 (vectored). A write of 2 or 3 keeps the old MODE and still updates BASE.
- mepc: bits [1:0] read 0. mcause and mtval are fully writable. mscratch is fully writable.
- mip: MEIP[11], MTIP[7] and MSIP[3] come from the synchronised inputs. mip is read-only, and writes to it are ignored without being flagged illegal.
- mcountinhibit: only CY[0] and IR[2] are writable.
- Counters:
  - mcycle increments every cycle unless CY is set.
  - minstret increments on retire unless IR is set.
  - A CSR write to a counter in the same cycle wins over the increment.
- Illegal accesses:
  - any unimplemented address;
  - addr[11:10] == 2'b11 (read-only space) with op RW, or with op RS/RC and csr_wdata != 0.
- Event priority within one cycle: exc_valid > irq_ack > mret_valid > CSR write. Lower-priority events in that cycle are dropped.
- Trap entry (exception or interrupt ack):
  - mepc ← PC; mcause ← {interrupt bit, code}; mtval ← exc_tval for exceptions, 0 for interrupts.
  - MPIE ← MIE, MIE ← 0.
  - redirect_pc = BASE. In vectored mode, interrupts use BASE + 4·code.
- MRET: MIE ← MPIE, MPIE ← 1, redirect_pc = mepc.
- irq_pending = mstatus.MIE & |(mip & mie). Code priority is 11 > 3 > 7.

## Timing
- csr_rdata and csr_illegal settle in the same cycle as the request. Written values are visible on the next cycle.
- redirect_valid pulses exactly one cycle after the exc/irq_ack/mret edge, with redirect_pc held stable during the pulse.
- An irq input edge reaches mip after IRQ_SYNC_STAGES clk edges. irq_pending follows combinationally from the registers.
- Back-to-back traps on consecutive cycles each produce their own redirect pulse.
- rst_n assertion mid-operation clears everything immediately, including the synchronisers and any pending redirect.

## Configuration
- CSR_HPM_EN defined: implements mhpmcounter3..3+NUM_HPM-1 and mhpmevent3..3+NUM_HPM-1.
  - Counter n increments on retire when mhpmevent n == 1.
  - Inhibit bits 3+ of mcountinhibit become writable.
- CSR_HPM_EN undefined: those addresses read 0, ignore writes and are not flagged illegal.

## Structure
- Package riscv_csr_pkg holds:
  - CSR address constants and csr_op encodings;
  - cause codes (MEI=11, MSI=3, MTI=7);
  - mstatus/mip bit positions and write-mask constants.
- Sub-module riscv_csr_irq_sync is a parametrised IRQ_SYNC_STAGES-deep synchroniser, instantiated once per interrupt line.

## Test plan
- Mask and mode rules:
  - CSRRS to mstatus with wdata=64'hFFFF_FFFF_FFFF_FFFF → reads back 64'h1888.
  - mtvec write 64'h8000_0003 → reads 64'h8000_0000 with the old MODE kept.
- exc_valid with code 2, pc 0x8000_0100, tval 0xDEAD → next cycle: mepc=0x8000_0100, mcause=2, mtval=0xDEAD, MIE=0, redirect_pc=mtvec BASE.
- Vectored interrupt:
  - Setup: mtvec=0x8000_0001, mie.MTIE=1, mstatus.MIE=1.
  - Stimulus: raise irq_timer.
  - Response: irq_pending asserts after 2 cycles with irq_code=7; irq_ack → redirect_pc=0x8000_001C, mcause=0x8000…0007.
- exc_valid, irq_ack and mret_valid in the same cycle → only the exception is taken. A following MRET restores MIE=1 and MPIE=1.
- Counter write priority:
  - CSRRW mcycle=100 → reads 101 one cycle later.
  - mcountinhibit=5 → both counters freeze.
  - CSRRW to mhartid (0xF14) → csr_illegal=1.
- Assert rst_n low during a redirect pulse → redirect_valid drops immediately. After release, mstatus=0x1800.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// rtl/riscv_csr_pkg.sv - CSR addresses, op encodings, cause codes, bit positions and write masks
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [1:0] CSR_OP_READ = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIP_MSIP_BIT     = 3;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  localparam logic [63:0] MIE_WMASK       = 64'h888;
  localparam logic [63:0] MCOUNTINH_WMASK = 64'h5;

  function automatic logic [63:0] csr_rmw(input logic [1:0] op, input logic [63:0] old_v,
                                          input logic [63:0] arg);
    case (op)
      CSR_OP_RW: return arg;
      CSR_OP_RS: return old_v | arg;
      CSR_OP_RC: return old_v & ~arg;
      default:   return old_v;
    endcase
  endfunction

endpackage

// File: rtl/riscv_csr_irq_sync.sv
// rtl/riscv_csr_irq_sync.sv - STAGES-deep flop synchroniser for one asynchronous interrupt level
module riscv_csr_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  output logic irq_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], irq_in};
  end

  assign irq_sync = sync_q[STAGES-1];

endmodule

// File: rtl/riscv_mcsr_unit.sv
// rtl/riscv_mcsr_unit.sv - machine-mode CSR unit with traps, interrupts and counters
// Define CSR_HPM_EN to implement the mhpmcounter/mhpmevent pairs.
module riscv_mcsr_unit
  import riscv_csr_pkg::*;
#(
  parameter int          XLEN            = 64,
  parameter int          HART_ID         = 0,
  parameter logic [63:0] MISA_VAL        = 64'h8000_0000_0014_1101,
  parameter int          IRQ_SYNC_STAGES = 2,
  parameter int          NUM_HPM         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_req,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            irq_pending,
  output logic [4:0]      irq_code,
  input  logic            irq_ack,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mret_valid,
  input  logic            retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mie_o
);

`ifdef CSR_HPM_EN
  localparam bit HPM_ON = 1'b1;
`else
  localparam bit HPM_ON = 1'b0;
`endif
  localparam logic [63:0] INH_MASK =
    MCOUNTINH_WMASK | (HPM_ON ? (((64'd1 << NUM_HPM) - 64'd1) << 3) : 64'd0);

  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_r, mtvec, mscratch, mepc, mcause, mtval, mcountinh;
  logic [XLEN-1:0] mcycle, minstret;
  logic            irq_ext_s, irq_timer_s, irq_soft_s;
  logic [XLEN-1:0] mstatus_val, mip_val, irq_en, rdata, hpm_rdata, wv;
  logic [63:0]     wv64;
  logic            impl, ro_write, csr_we, csr_commit, is_hpm_cnt, is_hpm_evt;
  logic [XLEN-1:0] mtvec_base, exc_cause, irq_cause, vec_off;

  riscv_csr_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_ext (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_ext), .irq_sync(irq_ext_s));
  riscv_csr_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_timer (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_timer), .irq_sync(irq_timer_s));
  riscv_csr_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_soft (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_soft), .irq_sync(irq_soft_s));

  always_comb begin
    mstatus_val                   = '0;
    mstatus_val[12:11]            = 2'b11;
    mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie;
    mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie;
    mip_val                       = '0;
    mip_val[MIP_MEIP_BIT]         = irq_ext_s;
    mip_val[MIP_MTIP_BIT]         = irq_timer_s;
    mip_val[MIP_MSIP_BIT]         = irq_soft_s;
  end

  assign is_hpm_cnt = (csr_addr[11:5] == 7'b1011000) && (csr_addr[4:0] >= 5'd3);
  assign is_hpm_evt = (csr_addr[11:5] == 7'b0011001) && (csr_addr[4:0] >= 5'd3);

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:       rdata = mstatus_val;
      CSR_MISA:          rdata = MISA_VAL[XLEN-1:0];
      CSR_MIE:           rdata = mie_r;
      CSR_MTVEC:         rdata = mtvec;
      CSR_MCOUNTINHIBIT: rdata = mcountinh;
      CSR_MSCRATCH:      rdata = mscratch;
      CSR_MEPC:          rdata = mepc;
      CSR_MCAUSE:        rdata = mcause;
      CSR_MTVAL:         rdata = mtval;
      CSR_MIP:           rdata = mip_val;
      CSR_MCYCLE:        rdata = mcycle;
      CSR_MINSTRET:      rdata = minstret;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
      CSR_MHARTID:       rdata = XLEN'(HART_ID);
      default: begin
        if (is_hpm_cnt || is_hpm_evt) rdata = hpm_rdata;
        else                          impl  = 1'b0;
      end
    endcase
  end

  // Read-only space rejects any op that could modify; RS/RC with zero operand is a pure read.
  assign ro_write    = (csr_addr[11:10] == 2'b11) &&
                       ((csr_op == CSR_OP_RW) || (csr_op[1] && (csr_wdata != '0)));
  assign csr_illegal = csr_req && (!impl || ro_write);
  assign csr_we      = csr_req && !csr_illegal && (csr_op != CSR_OP_READ);
  assign csr_commit  = csr_we && !exc_valid && !irq_ack && !mret_valid;
  assign csr_rdata   = rdata;
  assign wv64        = csr_rmw(csr_op, 64'(rdata), 64'(csr_wdata));
  assign wv          = wv64[XLEN-1:0];

  assign irq_en = mip_val & mie_r;
  always_comb begin
    irq_code = 5'd0;
    if      (irq_en[MIP_MEIP_BIT]) irq_code = CAUSE_MEI;
    else if (irq_en[MIP_MSIP_BIT]) irq_code = CAUSE_MSI;
    else if (irq_en[MIP_MTIP_BIT]) irq_code = CAUSE_MTI;
  end
  assign irq_pending = mstatus_mie && (irq_en != '0);

  assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};
  assign exc_cause  = {{(XLEN-5){1'b0}}, exc_code};
  assign irq_cause  = {1'b1, {(XLEN-6){1'b0}}, irq_code};
  assign vec_off    = {{(XLEN-7){1'b0}}, irq_code, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_r          <= '0;
      mtvec          <= '0;
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mcountinh      <= '0;
      mcycle         <= '0;
      minstret       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= exc_valid || irq_ack || mret_valid;
      if (!mcountinh[0])           mcycle   <= mcycle + XLEN'(1);
      if (retire && !mcountinh[2]) minstret <= minstret + XLEN'(1);
      if (exc_valid) begin
        mepc         <= {exc_pc[XLEN-1:2], 2'b00};
        mcause       <= exc_cause;
        mtval        <= exc_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        redirect_pc  <= mtvec_base;
      end else if (irq_ack) begin
        mepc         <= {irq_pc[XLEN-1:2], 2'b00};
        mcause       <= irq_cause;
        mtval        <= '0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        redirect_pc  <= (mtvec[1:0] == MTVEC_VECTORED) ? mtvec_base + vec_off : mtvec_base;
      end else if (mret_valid) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        redirect_pc  <= mepc;
      end
      // Placed after the increments so a same-cycle counter write takes precedence.
      if (csr_commit) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= wv[MSTATUS_MIE_BIT];
            mstatus_mpie <= wv[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:           mie_r     <= wv & MIE_WMASK[XLEN-1:0];
          CSR_MTVEC:         mtvec     <= {wv[XLEN-1:2], wv[1] ? mtvec[1:0] : wv[1:0]};
          CSR_MCOUNTINHIBIT: mcountinh <= wv & INH_MASK[XLEN-1:0];
          CSR_MSCRATCH:      mscratch  <= wv;
          CSR_MEPC:          mepc      <= {wv[XLEN-1:2], 2'b00};
          CSR_MCAUSE:        mcause    <= wv;
          CSR_MTVAL:         mtval     <= wv;
          CSR_MCYCLE:        mcycle    <= wv;
          CSR_MINSTRET:      minstret  <= wv;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_HPM_EN
  logic [4:0]      hpm_idx;
  logic [XLEN-1:0] hpm_cnt [NUM_HPM];
  logic [XLEN-1:0] hpm_evt [NUM_HPM];

  assign hpm_idx = csr_addr[4:0] - 5'd3;

  always_comb begin
    hpm_rdata = '0;
    for (int i = 0; i < NUM_HPM; i++)
      if (hpm_idx == 5'(i)) hpm_rdata = is_hpm_cnt ? hpm_cnt[i] : hpm_evt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HPM; i++) begin
        hpm_cnt[i] <= '0;
        hpm_evt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_HPM; i++) begin
        if (retire && (hpm_evt[i] == XLEN'(1)) && !mcountinh[3+i])
          hpm_cnt[i] <= hpm_cnt[i] + XLEN'(1);
        if (csr_commit && is_hpm_cnt && (hpm_idx == 5'(i))) hpm_cnt[i] <= wv;
        if (csr_commit && is_hpm_evt && (hpm_idx == 5'(i))) hpm_evt[i] <= wv;
      end
    end
  end
`else
  assign hpm_rdata = '0;
`endif

  assign mstatus_o = mstatus_val;
  assign mie_o     = mie_r;

endmodule

// File: tb/tb_riscv_mcsr_unit.sv
// tb/tb_riscv_mcsr_unit.sv - directed self-checking bench for riscv_mcsr_unit (default build)
module tb_riscv_mcsr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [63:0] exc_pc, exc_tval;
  logic        irq_ext, irq_timer, irq_soft;
  logic        irq_pending;
  logic [4:0]  irq_code;
  logic        irq_ack;
  logic [63:0] irq_pc;
  logic        mret_valid, retire;
  logic        redirect_valid;
  logic [63:0] redirect_pc, mstatus_o, mie_o;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_mcsr_unit dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .irq_pending(irq_pending), .irq_code(irq_code), .irq_ack(irq_ack), .irq_pc(irq_pc),
    .mret_valid(mret_valid), .retire(retire),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mstatus_o(mstatus_o), .mie_o(mie_o)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    csr_req = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_req = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [63:0] d);
    csr_req = 1'b1; csr_op = 2'b00; csr_addr = a;
    #1;
    d = csr_rdata;
    csr_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] v;
    rst_n = 1'b0;
    csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0; irq_ack = 0; irq_pc = 0;
    mret_valid = 0; retire = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b want 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 64'h0) begin n_fail++; $display("FAIL reset_rpc got %h want 0", redirect_pc); end
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b want 0", irq_pending); end
    n_checks++; if (mstatus_o !== 64'h1800) begin n_fail++; $display("FAIL reset_mstatus got %h want 1800", mstatus_o); end
    n_checks++; if (mie_o !== 64'h0) begin n_fail++; $display("FAIL reset_mie got %h want 0", mie_o); end
    rd(12'h305, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL reset_mtvec got %h want 0", v); end
  endtask

  task automatic test_mask_mode;
    logic [63:0] v;
    wr(2'b10, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF); rd(12'h300, v);
    n_checks++; if (v !== 64'h1888) begin n_fail++; $display("FAIL mstatus_rs got %h want 1888", v); end
    wr(2'b01, 12'h300, 64'h0); rd(12'h300, v);
    n_checks++; if (v !== 64'h1800) begin n_fail++; $display("FAIL mstatus_rw0 got %h want 1800", v); end
    wr(2'b01, 12'h305, 64'h8000_0003); rd(12'h305, v);
    n_checks++; if (v !== 64'h8000_0000) begin n_fail++; $display("FAIL mtvec_mode3 got %h want 80000000", v); end
    wr(2'b01, 12'h305, 64'h1000_0001); rd(12'h305, v);
    n_checks++; if (v !== 64'h1000_0001) begin n_fail++; $display("FAIL mtvec_vec got %h want 10000001", v); end
    wr(2'b01, 12'h305, 64'h2000_0002); rd(12'h305, v);
    n_checks++; if (v !== 64'h2000_0001) begin n_fail++; $display("FAIL mtvec_mode2 got %h want 20000001", v); end
    wr(2'b01, 12'h341, 64'h1233); rd(12'h341, v);
    n_checks++; if (v !== 64'h1230) begin n_fail++; $display("FAIL mepc_align got %h want 1230", v); end
    wr(2'b01, 12'h340, 64'hFFFF); wr(2'b11, 12'h340, 64'h00F0); rd(12'h340, v);
    n_checks++; if (v !== 64'hFF0F) begin n_fail++; $display("FAIL mscratch_rc got %h want ff0f", v); end
    wr(2'b01, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF); rd(12'h304, v);
    n_checks++; if (v !== 64'h888) begin n_fail++; $display("FAIL mie_mask got %h want 888", v); end
    wr(2'b01, 12'h304, 64'h0);
  endtask

  task automatic test_exception;
    logic [63:0] v;
    wr(2'b10, 12'h300, 64'h8);
    @(negedge clk);
    exc_valid = 1; exc_code = 5'd2; exc_pc = 64'h8000_0100; exc_tval = 64'hDEAD;
    @(posedge clk); #1; exc_valid = 0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL exc_rv got %b want 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 64'h2000_0000) begin n_fail++; $display("FAIL exc_rpc got %h want 20000000", redirect_pc); end
    n_checks++; if (mstatus_o !== 64'h1880) begin n_fail++; $display("FAIL exc_mstatus got %h want 1880", mstatus_o); end
    rd(12'h341, v);
    n_checks++; if (v !== 64'h8000_0100) begin n_fail++; $display("FAIL exc_mepc got %h want 80000100", v); end
    rd(12'h342, v);
    n_checks++; if (v !== 64'h2) begin n_fail++; $display("FAIL exc_mcause got %h want 2", v); end
    rd(12'h343, v);
    n_checks++; if (v !== 64'hDEAD) begin n_fail++; $display("FAIL exc_mtval got %h want dead", v); end
    @(posedge clk); #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL exc_pulse_end got %b want 0", redirect_valid); end
  endtask

  task automatic test_vectored_irq;
    logic [63:0] v;
    wr(2'b01, 12'h305, 64'h8000_0001);
    wr(2'b01, 12'h304, 64'h80);
    wr(2'b10, 12'h300, 64'h8);
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b want 0", irq_pending); end
    @(negedge clk); irq_timer = 1;
    @(posedge clk); #1;
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_sync1 got %b want 0", irq_pending); end
    @(posedge clk); #1;
    n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_sync2 got %b want 1", irq_pending); end
    n_checks++; if (irq_code !== 5'd7) begin n_fail++; $display("FAIL irq_code_t got %0d want 7", irq_code); end
    @(negedge clk); irq_ack = 1; irq_pc = 64'h8000_0200;
    @(posedge clk); #1; irq_ack = 0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL irq_rv got %b want 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 64'h8000_001C) begin n_fail++; $display("FAIL irq_rpc got %h want 8000001c", redirect_pc); end
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want 0", irq_pending); end
    rd(12'h342, v);
    n_checks++; if (v !== 64'h8000_0000_0000_0007) begin n_fail++; $display("FAIL irq_mcause got %h want 8000000000000007", v); end
    rd(12'h341, v);
    n_checks++; if (v !== 64'h8000_0200) begin n_fail++; $display("FAIL irq_mepc got %h want 80000200", v); end
    rd(12'h343, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL irq_mtval got %h want 0", v); end
    @(negedge clk); irq_timer = 0;
  endtask

  task automatic test_irq_priority;
    logic [63:0] v;
    wr(2'b01, 12'h304, 64'h888);
    wr(2'b10, 12'h300, 64'h8);
    @(negedge clk); irq_soft = 1; irq_timer = 1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (irq_code !== 5'd3) begin n_fail++; $display("FAIL prio_soft got %0d want 3", irq_code); end
    @(negedge clk); irq_ext = 1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (irq_code !== 5'd11) begin n_fail++; $display("FAIL prio_ext got %0d want 11", irq_code); end
    rd(12'h344, v);
    n_checks++; if (v !== 64'h888) begin n_fail++; $display("FAIL mip_read got %h want 888", v); end
    csr_req = 1; csr_op = 2'b01; csr_addr = 12'h344; csr_wdata = 64'h0; #1;
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL mip_wr_legal got %b want 0", csr_illegal); end
    csr_req = 0; csr_op = 2'b00;
    @(negedge clk); irq_ext = 0; irq_soft = 0; irq_timer = 0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL prio_clear got %b want 0", irq_pending); end
    wr(2'b01, 12'h304, 64'h0);
  endtask

  task automatic test_priority;
    logic [63:0] v;
    @(negedge clk);
    exc_valid = 1; exc_code = 5'd5; exc_pc = 64'h100; exc_tval = 64'h55;
    irq_ack = 1; irq_pc = 64'h200; mret_valid = 1;
    csr_req = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 64'h77;
    @(posedge clk); #1;
    exc_valid = 0; irq_ack = 0; mret_valid = 0; csr_req = 0; csr_op = 2'b00;
    n_checks++; if (redirect_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL same_rpc got %h want 80000000", redirect_pc); end
    n_checks++; if (mstatus_o !== 64'h1880) begin n_fail++; $display("FAIL same_mstatus got %h want 1880", mstatus_o); end
    rd(12'h342, v);
    n_checks++; if (v !== 64'h5) begin n_fail++; $display("FAIL same_mcause got %h want 5", v); end
    rd(12'h341, v);
    n_checks++; if (v !== 64'h100) begin n_fail++; $display("FAIL same_mepc got %h want 100", v); end
    rd(12'h340, v);
    n_checks++; if (v !== 64'hFF0F) begin n_fail++; $display("FAIL same_csr_drop got %h want ff0f", v); end
    @(negedge clk); mret_valid = 1;
    @(posedge clk); #1; mret_valid = 0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL mret_rv got %b want 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 64'h100) begin n_fail++; $display("FAIL mret_rpc got %h want 100", redirect_pc); end
    n_checks++; if (mstatus_o !== 64'h1888) begin n_fail++; $display("FAIL mret_mstatus got %h want 1888", mstatus_o); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    exc_valid = 1; exc_code = 5'd3; exc_pc = 64'h300; exc_tval = 64'h0;
    @(posedge clk); #1;
    exc_valid = 0; mret_valid = 1;
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0000) begin
      n_fail++; $display("FAIL b2b_first got %b/%h want 1/80000000", redirect_valid, redirect_pc); end
    @(posedge clk); #1; mret_valid = 0;
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h300) begin
      n_fail++; $display("FAIL b2b_second got %b/%h want 1/300", redirect_valid, redirect_pc); end
    n_checks++; if (mstatus_o !== 64'h1888) begin n_fail++; $display("FAIL b2b_mstatus got %h want 1888", mstatus_o); end
    @(posedge clk); #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", redirect_valid); end
  endtask

  task automatic test_counters;
    logic [63:0] v, c0, i0;
    wr(2'b01, 12'hB00, 64'd100); rd(12'hB00, v);
    n_checks++; if (v !== 64'd100) begin n_fail++; $display("FAIL mcycle_wr got %0d want 100", v); end
    @(posedge clk); #1; rd(12'hB00, v);
    n_checks++; if (v !== 64'd101) begin n_fail++; $display("FAIL mcycle_inc got %0d want 101", v); end
    wr(2'b01, 12'hB02, 64'd50);
    @(negedge clk); retire = 1;
    repeat (3) @(posedge clk); #1; retire = 0;
    rd(12'hB02, v);
    n_checks++; if (v !== 64'd53) begin n_fail++; $display("FAIL minstret_inc got %0d want 53", v); end
    retire = 1;
    wr(2'b01, 12'hB02, 64'd10);
    retire = 0; rd(12'hB02, v);
    n_checks++; if (v !== 64'd10) begin n_fail++; $display("FAIL minstret_wr_wins got %0d want 10", v); end
    wr(2'b01, 12'h320, 64'hFF); rd(12'h320, v);
    n_checks++; if (v !== 64'h5) begin n_fail++; $display("FAIL inhibit_mask got %h want 5", v); end
    rd(12'hB00, c0); rd(12'hB02, i0);
    @(negedge clk); retire = 1;
    repeat (2) @(posedge clk); #1; retire = 0;
    rd(12'hB00, v);
    n_checks++; if (v !== c0) begin n_fail++; $display("FAIL mcycle_frozen got %0d want %0d", v, c0); end
    rd(12'hB02, v);
    n_checks++; if (v !== i0) begin n_fail++; $display("FAIL minstret_frozen got %0d want %0d", v, i0); end
    wr(2'b01, 12'h320, 64'h0); rd(12'hB00, c0);
    @(posedge clk); #1; rd(12'hB00, v);
    n_checks++; if (v !== c0 + 64'd1) begin n_fail++; $display("FAIL mcycle_resume got %0d want %0d", v, c0 + 64'd1); end
  endtask

  task automatic test_illegal;
    logic [63:0] v;
    @(negedge clk);
    csr_req = 1; csr_addr = 12'hF14; csr_op = 2'b01; csr_wdata = 64'h0; #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_ro_rw got %b want 1", csr_illegal); end
    csr_op = 2'b10; #1;
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_ro_rs0 got %b want 0", csr_illegal); end
    csr_wdata = 64'h1; #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_ro_rs1 got %b want 1", csr_illegal); end
    csr_op = 2'b11; #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_ro_rc1 got %b want 1", csr_illegal); end
    csr_req = 0; csr_op = 2'b00; csr_wdata = 64'h0;
    rd(12'hF14, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL mhartid got %h want 0", v); end
    @(negedge clk);
    csr_req = 1; csr_addr = 12'h7C0; csr_op = 2'b00; #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_unimpl got %b want 1", csr_illegal); end
    csr_req = 0; #1;
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_noreq got %b want 0", csr_illegal); end
    csr_req = 1; csr_addr = 12'hB05; csr_op = 2'b01; csr_wdata = 64'h5; #1;
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_hpm got %b want 0", csr_illegal); end
    csr_req = 0; csr_op = 2'b00; csr_wdata = 64'h0;
    @(posedge clk); #1;
    rd(12'hB05, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL hpm_read got %h want 0", v); end
    rd(12'h301, v);
    n_checks++; if (v !== 64'h8000_0000_0014_1101) begin n_fail++; $display("FAIL misa got %h want 8000000000141101", v); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] v;
    @(negedge clk);
    exc_valid = 1; exc_code = 5'd1; exc_pc = 64'h400; exc_tval = 64'h0;
    @(posedge clk); #1; exc_valid = 0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rv got %b want 1", redirect_valid); end
    #1; rst_n = 1'b0; #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_rv got %b want 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 64'h0) begin n_fail++; $display("FAIL rst_async_rpc got %h want 0", redirect_pc); end
    @(negedge clk); rst_n = 1'b1; #1;
    rd(12'h300, v);
    n_checks++; if (v !== 64'h1800) begin n_fail++; $display("FAIL rst_mstatus got %h want 1800", v); end
    rd(12'h341, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL rst_mepc got %h want 0", v); end
    rd(12'h342, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL rst_mcause got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_mask_mode();
    test_exception();
    test_vectored_irq();
    test_irq_priority();
    test_priority();
    test_back_to_back();
    test_counters();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
